// File: rtl/miriscv_decode_stage_pkg.sv
// Shared encodings and types for the RV32I decode stage: opcodes, ALU op codes,
// operand-select codes, load/store sizes, the decoded bundle and the buffer state.
package miriscv_decode_stage_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SLL    = 5'b00001;
  localparam logic [4:0] ALU_SLTS   = 5'b00010;
  localparam logic [4:0] ALU_SLTU   = 5'b00011;
  localparam logic [4:0] ALU_XOR    = 5'b00100;
  localparam logic [4:0] ALU_SRL    = 5'b00101;
  localparam logic [4:0] ALU_OR     = 5'b00110;
  localparam logic [4:0] ALU_AND    = 5'b00111;
  localparam logic [4:0] ALU_SUB    = 5'b01000;
  localparam logic [4:0] ALU_SRA    = 5'b01101;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;
  localparam logic [4:0] ALU_EQ     = 5'b11000;
  localparam logic [4:0] ALU_NE     = 5'b11001;
  localparam logic [4:0] ALU_LTS    = 5'b11100;
  localparam logic [4:0] ALU_GES    = 5'b11101;
  localparam logic [4:0] ALU_LTU    = 5'b11110;
  localparam logic [4:0] ALU_GEU    = 5'b11111;

  localparam logic [1:0] OP_A_RS1  = 2'd0;
  localparam logic [1:0] OP_A_PC   = 2'd1;
  localparam logic [1:0] OP_A_ZERO = 2'd2;

  localparam logic [2:0] OP_B_RS2   = 3'd0;
  localparam logic [2:0] OP_B_IMM_I = 3'd1;
  localparam logic [2:0] OP_B_IMM_U = 3'd2;
  localparam logic [2:0] OP_B_IMM_S = 3'd3;
  localparam logic [2:0] OP_B_INCR  = 3'd4;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef struct packed {
    logic [1:0]  op_a_sel;
    logic [2:0]  op_b_sel;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic        gpr_we;
    logic        wb_src_sel;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } bundle_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  // Register-register ALU op for funct7 = 0x00 (shared by OP and most of OP_IMM).
  function automatic logic [4:0] alu_base(input logic [2:0] funct3);
    case (funct3)
      3'd0:    alu_base = ALU_ADD;
      3'd1:    alu_base = ALU_SLL;
      3'd2:    alu_base = ALU_SLTS;
      3'd3:    alu_base = ALU_SLTU;
      3'd4:    alu_base = ALU_XOR;
      3'd5:    alu_base = ALU_SRL;
      3'd6:    alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_decode_comb.sv
// Purely combinational RV32I(+M) instruction decoder producing one control bundle.
module miriscv_decode_comb
  import miriscv_decode_stage_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 5,
  parameter bit EN_M         = 1'b0
) (
  input  logic [31:0]             instr,
  output bundle_t                 bundle,
  output logic [ALU_OP_WIDTH-1:0] alu_op
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [4:0]  alu_code;
  logic        illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    bundle     = '0;
    bundle.rs1 = instr[19:15];
    bundle.rs2 = instr[24:20];
    bundle.rd  = instr[11:7];
    alu_code   = ALU_ADD;
    illegal    = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        bundle.mem_req    = 1'b1;
        bundle.mem_size   = funct3;
        bundle.wb_src_sel = 1'b1;
        bundle.gpr_we     = 1'b1;
        bundle.op_b_sel   = OP_B_IMM_I;
        bundle.imm        = imm_i;
        illegal           = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
      end
      OPC_MISC_MEM: bundle.imm = imm_i;
      OPC_OP_IMM: begin
        bundle.gpr_we   = 1'b1;
        bundle.op_b_sel = OP_B_IMM_I;
        bundle.imm      = imm_i;
        alu_code        = alu_base(funct3);
        if (funct3 == 3'd1) begin
          illegal = (funct7 != 7'h00);
        end else if (funct3 == 3'd5) begin
          alu_code = funct7[5] ? ALU_SRA : ALU_SRL;
          illegal  = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
      end
      OPC_AUIPC: begin
        bundle.gpr_we   = 1'b1;
        bundle.op_a_sel = OP_A_PC;
        bundle.op_b_sel = OP_B_IMM_U;
        bundle.imm      = imm_u;
      end
      OPC_STORE: begin
        bundle.mem_req  = 1'b1;
        bundle.mem_we   = 1'b1;
        bundle.mem_size = funct3;
        bundle.op_b_sel = OP_B_IMM_S;
        bundle.imm      = imm_s;
        illegal         = (funct3 > 3'd2);
      end
      OPC_OP: begin
        bundle.gpr_we = 1'b1;
        case (funct7)
          7'h00: alu_code = alu_base(funct3);
          7'h20: begin
            if (funct3 == 3'd0)      alu_code = ALU_SUB;
            else if (funct3 == 3'd5) alu_code = ALU_SRA;
            else                     illegal  = 1'b1;
          end
          7'h01: begin
            if (EN_M) alu_code = {2'b10, funct3};
            else      illegal  = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        bundle.gpr_we   = 1'b1;
        bundle.op_a_sel = OP_A_ZERO;
        bundle.op_b_sel = OP_B_IMM_U;
        bundle.imm      = imm_u;
      end
      OPC_BRANCH: begin
        bundle.branch = 1'b1;
        bundle.imm    = imm_b;
        case (funct3)
          3'd0:    alu_code = ALU_EQ;
          3'd1:    alu_code = ALU_NE;
          3'd4:    alu_code = ALU_LTS;
          3'd5:    alu_code = ALU_GES;
          3'd6:    alu_code = ALU_LTU;
          3'd7:    alu_code = ALU_GEU;
          default: illegal  = 1'b1;
        endcase
      end
      OPC_JALR: begin
        bundle.jalr     = 1'b1;
        bundle.gpr_we   = 1'b1;
        bundle.op_a_sel = OP_A_PC;
        bundle.op_b_sel = OP_B_INCR;
        bundle.imm      = imm_i;
      end
      OPC_JAL: begin
        bundle.jal      = 1'b1;
        bundle.gpr_we   = 1'b1;
        bundle.op_a_sel = OP_A_PC;
        bundle.op_b_sel = OP_B_INCR;
        bundle.imm      = imm_j;
      end
      OPC_SYSTEM: bundle.imm = imm_i;
      default:    illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) illegal = 1'b1;
    // Illegal instructions still flow to execute, but must have no side effects.
    if (illegal) begin
      bundle.gpr_we  = 1'b0;
      bundle.mem_req = 1'b0;
      bundle.branch  = 1'b0;
      bundle.jal     = 1'b0;
      bundle.jalr    = 1'b0;
    end
    bundle.illegal = illegal;
  end

  assign alu_op = ALU_OP_WIDTH'(alu_code);

endmodule

// File: rtl/miriscv_decode_stage.sv
// Registered, handshaked decode stage: combinational decode into an output
// register, with an optional skid entry so in_ready_o never depends on out_ready_i.
module miriscv_decode_stage
  import miriscv_decode_stage_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 5,
  parameter bit EN_M         = 1'b0,
  parameter bit SKID_EN      = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             fetched_instr_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [1:0]              ex_op_a_sel_o,
  output logic [2:0]              ex_op_b_sel_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [2:0]              mem_size_o,
  output logic                    gpr_we_a_o,
  output logic                    wb_src_sel_o,
  output logic                    branch_o,
  output logic                    jal_o,
  output logic                    jalr_o,
  output logic                    illegal_instr_o,
  output logic [4:0]              rs1_o,
  output logic [4:0]              rs2_o,
  output logic [4:0]              rd_o,
  output logic [31:0]             imm_o
);

  bundle_t                 dec_p0, out_p1, skid_p2;
  logic [ALU_OP_WIDTH-1:0] dec_alu_p0, out_alu_p1, skid_alu_p2;
  state_t                  state, state_next;
  logic                    in_ready_q;
  logic                    accept, load_out_dec, load_out_skid, load_skid;

  // Stage p0: decode of the presented instruction
  miriscv_decode_comb #(
    .ALU_OP_WIDTH (ALU_OP_WIDTH),
    .EN_M         (EN_M)
  ) u_decode (
    .instr  (fetched_instr_i),
    .bundle (dec_p0),
    .alu_op (dec_alu_p0)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != ST_TWO);
    end
  end

  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_next = ST_ONE;
        ST_ONE: begin
          if (accept && !out_ready_i && SKID_EN) state_next = ST_TWO;
          else if (!accept && out_ready_i)       state_next = ST_EMPTY;
        end
        ST_TWO:   if (out_ready_i) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid_o = (state != ST_EMPTY);
    in_ready_o  = SKID_EN ? in_ready_q : (!out_valid_o || out_ready_i);
  end

  assign accept        = in_valid_i && in_ready_o && !flush_i;
  assign load_out_dec  = accept && ((state == ST_EMPTY) || ((state == ST_ONE) && out_ready_i));
  assign load_skid     = accept && (state == ST_ONE) && !out_ready_i;
  assign load_out_skid = !flush_i && (state == ST_TWO) && out_ready_i;

  // Stage p1 (output register) and p2 (skid entry)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_p1      <= '0;
      out_alu_p1  <= '0;
      skid_p2     <= '0;
      skid_alu_p2 <= '0;
    end else begin
      if (load_out_dec) begin
        out_p1     <= dec_p0;
        out_alu_p1 <= dec_alu_p0;
      end else if (load_out_skid) begin
        out_p1     <= skid_p2;
        out_alu_p1 <= skid_alu_p2;
      end
      if (load_skid) begin
        skid_p2     <= dec_p0;
        skid_alu_p2 <= dec_alu_p0;
      end
    end
  end

  assign ex_op_a_sel_o   = out_p1.op_a_sel;
  assign ex_op_b_sel_o   = out_p1.op_b_sel;
  assign alu_op_o        = out_alu_p1;
  assign mem_req_o       = out_p1.mem_req;
  assign mem_we_o        = out_p1.mem_we;
  assign mem_size_o      = out_p1.mem_size;
  assign gpr_we_a_o      = out_p1.gpr_we;
  assign wb_src_sel_o    = out_p1.wb_src_sel;
  assign branch_o        = out_p1.branch;
  assign jal_o           = out_p1.jal;
  assign jalr_o          = out_p1.jalr;
  assign illegal_instr_o = out_p1.illegal;
  assign rs1_o           = out_p1.rs1;
  assign rs2_o           = out_p1.rs2;
  assign rd_o            = out_p1.rd;
  assign imm_o           = out_p1.imm;

endmodule

// File: tb/tb_miriscv_decode_stage.sv
// Directed bench for miriscv_decode_stage with an expected-bundle scoreboard.
module tb_miriscv_decode_stage;
  import miriscv_decode_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr;

  logic        in_ready, out_valid, mem_req, mem_we, gpr_we, wb_sel, br, jal, jalr, ill;
  logic [1:0]  a_sel;
  logic [2:0]  b_sel, mem_size;
  logic [4:0]  alu, rs1, rs2, rd;
  logic [31:0] imm;

  logic        in_ready_m, out_valid_m, mem_req_m, mem_we_m, gpr_we_m, wb_sel_m, br_m, jal_m, jalr_m, ill_m;
  logic [1:0]  a_sel_m;
  logic [2:0]  b_sel_m, mem_size_m;
  logic [4:0]  alu_m, rs1_m, rs2_m, rd_m;
  logic [31:0] imm_m;

  miriscv_decode_stage #(.ALU_OP_WIDTH(5), .EN_M(1'b0), .SKID_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fetched_instr_i(instr), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .ex_op_a_sel_o(a_sel), .ex_op_b_sel_o(b_sel), .alu_op_o(alu), .mem_req_o(mem_req),
    .mem_we_o(mem_we), .mem_size_o(mem_size), .gpr_we_a_o(gpr_we), .wb_src_sel_o(wb_sel),
    .branch_o(br), .jal_o(jal), .jalr_o(jalr), .illegal_instr_o(ill),
    .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .imm_o(imm)
  );

  miriscv_decode_stage #(.ALU_OP_WIDTH(5), .EN_M(1'b1), .SKID_EN(1'b1)) dut_m (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_m),
    .fetched_instr_i(instr), .out_valid_o(out_valid_m), .out_ready_i(out_ready),
    .ex_op_a_sel_o(a_sel_m), .ex_op_b_sel_o(b_sel_m), .alu_op_o(alu_m), .mem_req_o(mem_req_m),
    .mem_we_o(mem_we_m), .mem_size_o(mem_size_m), .gpr_we_a_o(gpr_we_m), .wb_src_sel_o(wb_sel_m),
    .branch_o(br_m), .jal_o(jal_m), .jalr_o(jalr_m), .illegal_instr_o(ill_m),
    .rs1_o(rs1_m), .rs2_o(rs2_m), .rd_o(rd_m), .imm_o(imm_m)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  alu;
    logic [1:0]  a;
    logic [2:0]  b;
    logic [31:0] imm;
    logic [7:0]  ctl;   // {gpr_we, mem_req, mem_we, wb_src, branch, jal, jalr, illegal}
    logic [2:0]  size;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  exp_t stream[$];
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t mk(input logic [31:0] i, input logic [4:0] alu_e, input logic [1:0] a_e,
                              input logic [2:0] b_e, input logic [31:0] imm_e,
                              input logic [7:0] ctl_e, input logic [2:0] size_e);
    exp_t e;
    e.instr = i; e.alu = alu_e; e.a = a_e; e.b = b_e; e.imm = imm_e; e.ctl = ctl_e; e.size = size_e;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    string t;
    t = $sformatf("%h", e.instr);
    if (e.ctl[0]) begin
      chk({t, "_ctl_ill"}, 64'({gpr_we, mem_req, br, jal, jalr, ill}),
          64'({e.ctl[7], e.ctl[6], e.ctl[3], e.ctl[2], e.ctl[1], e.ctl[0]}));
    end else begin
      chk({t, "_ctl"}, 64'({gpr_we, mem_req, mem_we, wb_sel, br, jal, jalr, ill}), 64'(e.ctl));
      chk({t, "_alu"}, 64'(alu), 64'(e.alu));
      chk({t, "_sel"}, 64'({a_sel, b_sel}), 64'({e.a, e.b}));
      chk({t, "_imm"}, 64'(imm), 64'(e.imm));
      chk({t, "_regs"}, 64'({rs1, rs2, rd}), 64'({e.instr[19:15], e.instr[24:20], e.instr[11:7]}));
      chk({t, "_size"}, 64'(mem_size), 64'(e.size));
    end
  endtask

  // One clock: score the handshakes visible at the falling edge, then step past the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'(0));
        else compare(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input exp_t e);
    in_valid = 1'b1;
    instr    = e.instr;
    cur      = e;
    cycle();
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    for (int n = 0; n < 8 && q.size() != 0; n++) cycle();
    chk(tag, 64'(q.size()), 64'(0));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_vld"}, 64'(out_valid), 64'(0));
    chk({tag, "_rdy"}, 64'(in_ready), 64'(1));
    chk({tag, "_bundle"}, 64'({a_sel, b_sel, alu, mem_req, mem_we, mem_size, gpr_we, wb_sel,
                               br, jal, jalr, ill, rs1, rs2, rd}), 64'(0));
    chk({tag, "_imm"}, 64'(imm), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e_addi5, e_addi10, e_mul;
    e_addi5  = mk(32'h00500093, ALU_ADD, 2'd0, 3'd1, 32'd5,  8'b1000_0000, 3'd0);
    e_addi10 = mk(32'h00A00113, ALU_ADD, 2'd0, 3'd1, 32'd10, 8'b1000_0000, 3'd0);
    e_mul    = mk(32'h022080B3, ALU_ADD, 2'd0, 3'd0, 32'd0,  8'b0000_0001, 3'd0);
    stream.push_back(mk(32'h40208133, ALU_SUB, 2'd0, 3'd0, 32'd0,          8'b1000_0000, 3'd0));
    stream.push_back(mk(32'h4020D093, ALU_SRA, 2'd0, 3'd1, 32'h402,        8'b1000_0000, 3'd0));
    stream.push_back(e_addi10);
    stream.push_back(mk(32'h0080A183, ALU_ADD, 2'd0, 3'd1, 32'd8,          8'b1101_0000, 3'd2));
    stream.push_back(mk(32'h0030A623, ALU_ADD, 2'd0, 3'd3, 32'd12,         8'b0110_0000, 3'd2));
    stream.push_back(mk(32'hFE208EE3, ALU_EQ,  2'd0, 3'd0, 32'hFFFFFFFC,   8'b0000_1000, 3'd0));
    stream.push_back(mk(32'h123452B7, ALU_ADD, 2'd2, 3'd2, 32'h12345000,   8'b1000_0000, 3'd0));
    stream.push_back(mk(32'h008000EF, ALU_ADD, 2'd1, 3'd4, 32'd8,          8'b1000_0100, 3'd0));
    stream.push_back(mk(32'h00000000, ALU_ADD, 2'd0, 3'd0, 32'd0,          8'b0000_0001, 3'd0));
    stream.push_back(mk(32'h0000B183, ALU_ADD, 2'd0, 3'd0, 32'd0,          8'b0000_0001, 3'd0));
    stream.push_back(mk(32'h40209133, ALU_ADD, 2'd0, 3'd0, 32'd0,          8'b0000_0001, 3'd0));
    stream.push_back(mk(32'hFE20AEE3, ALU_ADD, 2'd0, 3'd0, 32'd0,          8'b0000_0001, 3'd0));

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0; cur = e_addi5;
    repeat (2) cycle();
    rst = 1'b0;
    check_cleared("reset");

    // Streaming at full rate
    send(e_addi5);
    chk("latency_vld", 64'(out_valid), 64'(1));
    foreach (stream[i]) send(stream[i]);
    drain("stream_drain");

    // MUL: illegal without M, decoded with M
    send(e_mul);
    chk("mul_m_vld", 64'({out_valid_m, in_ready_m}), 64'(2'b11));
    chk("mul_m_bundle", 64'({a_sel_m, b_sel_m, alu_m, mem_req_m, mem_we_m, mem_size_m, gpr_we_m,
                             wb_sel_m, br_m, jal_m, jalr_m, ill_m, rs1_m, rs2_m, rd_m}),
        64'({2'd0, 3'd0, ALU_MUL, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             5'd1, 5'd2, 5'd1}));
    chk("mul_m_imm", 64'(imm_m), 64'(0));
    drain("mul_drain");

    // Back-pressure fills the skid entry
    out_ready = 1'b0;
    send(e_addi5);
    send(e_addi10);
    in_valid = 1'b0;
    chk("bp_full", 64'({in_ready, out_valid}), 64'(2'b01));
    cycle();
    chk("bp_hold", 64'({in_ready, out_valid, rd, imm}), 64'({1'b0, 1'b1, 5'd1, 32'd5}));
    out_ready = 1'b1;
    drain("bp_drain");
    chk("bp_ready_back", 64'(in_ready), 64'(1));

    // Flush while full, with a new instruction and out_ready both presented
    out_ready = 1'b0;
    send(stream[0]);
    send(stream[1]);
    chk("pre_flush_full", 64'(in_ready), 64'(0));
    in_valid = 1'b1; instr = stream[6].instr; cur = stream[6];
    flush = 1'b1; out_ready = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_state", 64'({out_valid, in_ready}), 64'(2'b01));
    repeat (4) cycle();
    chk("post_flush_quiet", 64'(out_valid), 64'(0));

    // Reset while full
    out_ready = 1'b0;
    send(stream[3]);
    send(stream[4]);
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_cleared("mid_reset");
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("post_reset_quiet", 64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
